// File: rtl/level_meter.sv
// level_meter: N-segment level meter with instant attack, timed release and bar/dot display.
// Define LEVEL_METER_PEAK_EN to build the peak-hold register, peak FSM and peak dot.
module level_meter #(
    parameter int N           = 16,
    parameter int DECAY_TICKS = 10,
    parameter int HOLD_TICKS  = 100,
    localparam int LW         = $clog2(N + 1)
) (
    input  logic          hz100,
    input  logic          reset,
    input  logic [N-1:0]  in,
    input  logic          mode,
    input  logic          freeze,
    output logic [N-1:0]  out,
    output logic [LW-1:0] level,
    output logic [LW-1:0] peak
);
    localparam int MT = DECAY_TICKS > HOLD_TICKS ? DECAY_TICKS : HOLD_TICKS;
    localparam int CW = $clog2(MT + 1);

    logic [LW-1:0] raw, level_next;
    logic [CW-1:0] dcnt, dcnt_next;
    logic [N-1:0]  pdot;

    always_comb begin
        raw = '0;
        for (int i = 0; i < N; i++)
            if (in[i]) raw = LW'(i + 1);
    end

    always_comb begin
        level_next = level;
        dcnt_next  = dcnt;
        if (!freeze) begin
            if (raw >= level) begin
                level_next = raw;
                dcnt_next  = '0;
            end else if (dcnt == CW'(DECAY_TICKS - 1)) begin
                level_next = level - LW'(1);
                dcnt_next  = '0;
            end else begin
                dcnt_next = dcnt + CW'(1);
            end
        end
    end

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            level <= '0;
            dcnt  <= '0;
        end else begin
            level <= level_next;
            dcnt  <= dcnt_next;
        end
    end

`ifdef LEVEL_METER_PEAK_EN
    typedef enum logic [1:0] {TRACK, HOLD, FALL} pstate_t;

    pstate_t       state, state_next;
    logic [CW-1:0] pcnt, pcnt_next;
    logic [LW-1:0] peak_next;

    // A new maximum always wins over the hold/fall progress and restarts HOLD.
    always_comb begin
        state_next = state;
        peak_next  = peak;
        pcnt_next  = pcnt;
        if (!freeze) begin
            if (level_next > peak) begin
                peak_next  = level_next;
                state_next = HOLD;
                pcnt_next  = '0;
            end else begin
                case (state)
                    TRACK: peak_next = level_next;
                    HOLD: begin
                        if (pcnt == CW'(HOLD_TICKS - 1)) begin
                            state_next = FALL;
                            pcnt_next  = '0;
                        end else begin
                            pcnt_next = pcnt + CW'(1);
                        end
                    end
                    FALL: begin
                        if (pcnt == CW'(DECAY_TICKS - 1)) begin
                            pcnt_next = '0;
                            if (peak - LW'(1) <= level_next) begin
                                peak_next  = level_next;
                                state_next = TRACK;
                            end else begin
                                peak_next = peak - LW'(1);
                            end
                        end else begin
                            pcnt_next = pcnt + CW'(1);
                        end
                    end
                    default: state_next = TRACK;
                endcase
            end
        end
    end

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            state <= TRACK;
            peak  <= '0;
            pcnt  <= '0;
        end else begin
            state <= state_next;
            peak  <= peak_next;
            pcnt  <= pcnt_next;
        end
    end

    always_comb begin
        pdot = '0;
        for (int i = 0; i < N; i++)
            pdot[i] = (peak > level) && (LW'(i + 1) == peak);
    end
`else
    assign peak = '0;
    assign pdot = '0;
`endif

    always_comb begin
        out = pdot;
        for (int i = 0; i < N; i++)
            if (mode ? (LW'(i + 1) == level) : (LW'(i) < level)) out[i] = 1'b1;
    end
endmodule
